// File: rtl/pcap_capture_sequencer.sv
// pcap_capture_sequencer
//   Control-side sequencer for the position-capture datapath. The host fills
//   a table of capture-field indices. On each qualified capture the table is
//   walked one entry per clock to steer the capture mux. The block also owns
//   the arm/disarm/active lifecycle and reports done/status to the host.
//
// Optional build macro: PCAP_SEQ_LIMIT_EN
//   Adds max_samples_i / sample_count_o. The acquisition then ends (status OK)
//   once the number of completed sequences reaches a nonzero max_samples_i.
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_write_i       clear table (length 0, overflow flag cleared)
//   write_i             table data, low IDX_W bits stored
//   write_wstb_i        append write_i to table (IDLE only)
//   arm_i / disarm_i    start / abort acquisition
//   enable_i            level gate for captures; falling edge ends acquisition
//   capture_i           capture request
//   dma_full_i          downstream full, aborts acquisition
//   mux_idx_o           registered capture-mux field index
//   mux_valid_o         mux_idx_o valid this cycle
//   actv_o              acquisition active
//   done_o              one-cycle pulse at end of acquisition
//   status_o            end reason: 0 OK, 1 disarm, 2 overrun, 3 DMA full, 4 table overflow
module pcap_capture_sequencer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_write_i,
    input  logic [31:0]      write_i,
    input  logic             write_wstb_i,
    input  logic             arm_i,
    input  logic             disarm_i,
    input  logic             enable_i,
    input  logic             capture_i,
    input  logic             dma_full_i,
`ifdef PCAP_SEQ_LIMIT_EN
    input  logic [31:0]      max_samples_i,
    output logic [31:0]      sample_count_o,
`endif
    output logic [IDX_W-1:0] mux_idx_o,
    output logic             mux_valid_o,
    output logic             actv_o,
    output logic             done_o,
    output logic [2:0]       status_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_DISARM  = 3'd1;
    localparam logic [2:0] ST_OVERRUN = 3'd2;
    localparam logic [2:0] ST_DMA     = 3'd3;
    localparam logic [2:0] ST_TBL_OVF = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SEQ
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_table [DEPTH];
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_en_d;
    logic             r_end_pend;
    logic [IDX_W-1:0] r_mux_idx;
    logic             r_mux_valid;
    logic             r_actv;
    logic             r_done;
    logic [2:0]       r_status;

    logic             w_idle;
    logic             w_qcap;
    logic             w_en_fall;
    logic             w_last;
    logic             w_arm_ok;
    logic             w_seq_done;
    logic             w_limit_hit;
    logic             w_tbl_we;
    logic [PTR_W-1:0] w_tbl_waddr;
    logic             w_end;
    logic [2:0]       w_end_status;
    logic             w_unused_write;

    assign w_unused_write = ^write_i[31:IDX_W];

    assign w_idle     = (r_state == S_IDLE);
    assign w_qcap     = capture_i & enable_i;
    assign w_en_fall  = r_en_d & ~enable_i;
    assign w_last     = (LEN_W'(r_rd_ptr) == (r_len - LEN_W'(1)));
    assign w_arm_ok   = w_idle & arm_i & ~r_ovf & (r_len != '0);
    // A sequence only counts as completed if its last entry is actually issued.
    assign w_seq_done = (r_state == S_SEQ) & w_last & ~dma_full_i & ~disarm_i;

    // Simultaneous clear+append stores the new entry at index 0.
    assign w_tbl_we    = ~reset_i & w_idle & write_wstb_i & (start_write_i | (r_len != FULL_LEN));
    assign w_tbl_waddr = start_write_i ? '0 : r_len[PTR_W-1:0];

`ifdef PCAP_SEQ_LIMIT_EN
    logic [31:0] r_sample_count;

    assign sample_count_o = r_sample_count;
    assign w_limit_hit    = (max_samples_i != '0) &&
                            (({1'b0, r_sample_count} + 33'd1) >= {1'b0, max_samples_i});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sample_count <= '0;
        end else if (w_arm_ok) begin
            r_sample_count <= '0;
        end else if (w_seq_done) begin
            r_sample_count <= r_sample_count + 32'd1;
        end
    end
`else
    assign w_limit_hit = 1'b0;
`endif

    // Abort/end decision, in priority order: DMA full, overrun, disarm,
    // then a pending enable-fall/limit end (only taken from ARMED so an
    // in-flight sequence finishes first).
    always_comb begin
        w_end        = 1'b0;
        w_end_status = ST_OK;
        if (r_state != S_IDLE) begin
            if (dma_full_i) begin
                w_end        = 1'b1;
                w_end_status = ST_DMA;
            end else if ((r_state == S_SEQ) && w_qcap && !w_last) begin
                w_end        = 1'b1;
                w_end_status = ST_OVERRUN;
            end else if (disarm_i) begin
                w_end        = 1'b1;
                w_end_status = ST_DISARM;
            end else if ((r_state == S_ARMED) && (r_end_pend || w_en_fall)) begin
                w_end        = 1'b1;
                w_end_status = ST_OK;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tbl_we) begin
            r_table[w_tbl_waddr] <= write_i[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_rd_ptr    <= '0;
            r_en_d      <= 1'b0;
            r_end_pend  <= 1'b0;
            r_mux_idx   <= '0;
            r_mux_valid <= 1'b0;
            r_actv      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= ST_OK;
        end else begin
            r_en_d      <= enable_i;
            r_done      <= 1'b0;
            r_mux_valid <= 1'b0;

            if (w_idle) begin
                if (start_write_i) begin
                    r_len <= write_wstb_i ? LEN_W'(1) : '0;
                    r_ovf <= 1'b0;
                end else if (write_wstb_i) begin
                    if (r_len == FULL_LEN) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_len <= r_len + LEN_W'(1);
                    end
                end
            end

            if (w_end) begin
                r_state    <= S_IDLE;
                r_actv     <= 1'b0;
                r_done     <= 1'b1;
                r_status   <= w_end_status;
                r_end_pend <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm_i && r_ovf) begin
                            r_done   <= 1'b1;
                            r_status <= ST_TBL_OVF;
                        end else if (w_arm_ok) begin
                            r_state    <= S_ARMED;
                            r_actv     <= 1'b1;
                            r_status   <= ST_OK;
                            r_end_pend <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (w_qcap) begin
                            r_state  <= S_SEQ;
                            r_rd_ptr <= '0;
                        end
                    end
                    S_SEQ: begin
                        r_mux_valid <= 1'b1;
                        r_mux_idx   <= r_table[r_rd_ptr];
                        if (w_last) begin
                            r_rd_ptr <= '0;
                            // An end request seen during the sequence is
                            // honoured from ARMED on the following edge, so the
                            // last entry is still issued and a back-to-back
                            // capture is not allowed to restart.
                            if (r_end_pend || w_en_fall || w_limit_hit) begin
                                r_state    <= S_ARMED;
                                r_end_pend <= 1'b1;
                            end else if (!w_qcap) begin
                                r_state <= S_ARMED;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                            if (w_en_fall) begin
                                r_end_pend <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mux_idx_o   = r_mux_idx;
    assign mux_valid_o = r_mux_valid;
    assign actv_o      = r_actv;
    assign done_o      = r_done;
    assign status_o    = r_status;

endmodule

// File: tb/tb_pcap_capture_sequencer.sv
// Bench for pcap_capture_sequencer: expected mux indices are queued as each
// capture is driven and popped by a monitor whenever mux_valid_o is high.
module tb_pcap_capture_sequencer;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned IDX_W = 6;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             start_write_i;
    logic [31:0]      write_i;
    logic             write_wstb_i;
    logic             arm_i;
    logic             disarm_i;
    logic             enable_i;
    logic             capture_i;
    logic             dma_full_i;
    logic [IDX_W-1:0] mux_idx_o;
    logic             mux_valid_o;
    logic             actv_o;
    logic             done_o;
    logic [2:0]       status_o;
`ifdef PCAP_SEQ_LIMIT_EN
    logic [31:0]      max_samples_i;
    logic [31:0]      sample_count_o;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned done_cnt    = 0;
    logic [IDX_W-1:0] exp_q [$];

    pcap_capture_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .start_write_i (start_write_i),
        .write_i       (write_i),
        .write_wstb_i  (write_wstb_i),
        .arm_i         (arm_i),
        .disarm_i      (disarm_i),
        .enable_i      (enable_i),
        .capture_i     (capture_i),
        .dma_full_i    (dma_full_i),
`ifdef PCAP_SEQ_LIMIT_EN
        .max_samples_i (max_samples_i),
        .sample_count_o(sample_count_o),
`endif
        .mux_idx_o     (mux_idx_o),
        .mux_valid_o   (mux_valid_o),
        .actv_o        (actv_o),
        .done_o        (done_o),
        .status_o      (status_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
        if (mux_valid_o === 1'b1) begin
            if (exp_q.size() == 0) check_val("spurious_valid", 32'(mux_valid_o), 32'd0);
            else check_val("mux_idx", 32'(mux_idx_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] v);
        write_i      = v;
        write_wstb_i = 1'b1;
        step();
        write_wstb_i = 1'b0;
    endtask

    task automatic clr();
        start_write_i = 1'b1;
        step();
        start_write_i = 1'b0;
    endtask

    task automatic arm();
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
    endtask

    task automatic cap();
        capture_i = 1'b1;
        step();
        capture_i = 1'b0;
    endtask

    task automatic push4();
        exp_q.push_back(6'd37);
        exp_q.push_back(6'd38);
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned d0;
        reset_i = 1'b1; start_write_i = 1'b0; write_i = '0; write_wstb_i = 1'b0;
        arm_i = 1'b0; disarm_i = 1'b0; enable_i = 1'b0; capture_i = 1'b0; dma_full_i = 1'b0;
`ifdef PCAP_SEQ_LIMIT_EN
        max_samples_i = '0;
`endif
        step(); step();
        reset_i = 1'b0;
        look();
        check_val("rst_valid",  32'(mux_valid_o), 32'd0);
        check_val("rst_idx",    32'(mux_idx_o),   32'd0);
        check_val("rst_actv",   32'(actv_o),      32'd0);
        check_val("rst_done",   32'(done_o),      32'd0);
        check_val("rst_status", 32'(status_o),    32'd0);

        // Table {37,38,0,5}; upper write bits must be ignored.
        clr();
        wr(32'hFFFF_FFE5); wr(32'd38); wr(32'd0); wr(32'd5);
        enable_i = 1'b1;
        arm();
        look();
        check_val("arm_actv", 32'(actv_o), 32'd1);
        check_val("arm_done", 32'(done_o), 32'd0);
        wr(32'd9); // not IDLE: must not extend the table

        // Single capture: latency and four entries.
        push4();
        cap();
        look();
        check_val("lat_valid0", 32'(mux_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); look();
            check_val("seq_valid", 32'(mux_valid_o), 32'd1);
        end
        step(); look();
        check_val("seq_end_valid", 32'(mux_valid_o), 32'd0);
        check_val("seq_end_actv",  32'(actv_o),      32'd1);

        // Back-to-back capture on the last-entry edge: 8 contiguous.
        push4();
        cap();
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                capture_i = 1'b1;
                push4();
            end
            step();
            capture_i = 1'b0;
            look();
            check_val("b2b_valid", 32'(mux_valid_o), 32'd1);
        end
        step(); look();
        check_val("b2b_valid_end", 32'(mux_valid_o), 32'd0);
        check_val("b2b_actv",      32'(actv_o),      32'd1);
        check_val("b2b_done_cnt",  done_cnt,         32'd0);

        // Overrun: second capture two edges after the first.
        exp_q.push_back(6'd37);
        cap();
        step();
        cap();
        look();
        check_val("ovr_valid",  32'(mux_valid_o), 32'd0);
        check_val("ovr_done",   32'(done_o),      32'd1);
        check_val("ovr_status", 32'(status_o),    32'd2);
        check_val("ovr_actv",   32'(actv_o),      32'd0);
        step(); look();
        check_val("ovr_done_pulse", 32'(done_o),   32'd0);
        check_val("ovr_status_hold", 32'(status_o), 32'd2);

        // Disarm mid-sequence.
        arm();
        look();
        check_val("rearm_status", 32'(status_o), 32'd0);
        exp_q.push_back(6'd37);
        exp_q.push_back(6'd38);
        cap();
        step(); step();
        disarm_i = 1'b1;
        step();
        disarm_i = 1'b0;
        look();
        check_val("dis_valid",  32'(mux_valid_o), 32'd0);
        check_val("dis_done",   32'(done_o),      32'd1);
        check_val("dis_status", 32'(status_o),    32'd1);
        check_val("dis_actv",   32'(actv_o),      32'd0);

        // DMA full beats disarm.
        arm();
        exp_q.push_back(6'd37);
        cap();
        step();
        dma_full_i = 1'b1; disarm_i = 1'b1;
        step();
        dma_full_i = 1'b0; disarm_i = 1'b0;
        look();
        check_val("pri_status", 32'(status_o),    32'd3);
        check_val("pri_done",   32'(done_o),      32'd1);
        check_val("pri_valid",  32'(mux_valid_o), 32'd0);

        // Enable falls during a sequence: it completes, then ends with OK.
        arm();
        push4();
        cap();
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); look();
            check_val("enf_valid", 32'(mux_valid_o), 32'd1);
            check_val("enf_nodone", 32'(done_o), 32'd0);
        end
        step(); look();
        check_val("enf_done",   32'(done_o),   32'd1);
        check_val("enf_status", 32'(status_o), 32'd0);
        check_val("enf_actv",   32'(actv_o),   32'd0);
        enable_i = 1'b1;

        // 65 writes overflow the table.
        clr();
        for (int i = 0; i < 65; i++) wr(32'(i));
        arm();
        look();
        check_val("tovf_done",   32'(done_o),   32'd1);
        check_val("tovf_status", 32'(status_o), 32'd4);
        check_val("tovf_actv",   32'(actv_o),   32'd0);
        step(); look();
        check_val("tovf_actv2",  32'(actv_o),   32'd0);

        // Empty table: arm ignored, status held.
        clr();
        d0 = done_cnt;
        arm();
        cap();
        step(); step(); look();
        check_val("empty_actv",   32'(actv_o),   32'd0);
        check_val("empty_done",   done_cnt - d0, 32'd0);
        check_val("empty_status", 32'(status_o), 32'd4);

        // Clear and append in the same cycle -> table {11,12}.
        start_write_i = 1'b1;
        wr(32'd11);
        start_write_i = 1'b0;
        wr(32'd12);
        arm();
        exp_q.push_back(6'd11);
        exp_q.push_back(6'd12);
        cap();
        step(); step(); step(); look();
        check_val("sw_actv", 32'(actv_o), 32'd1);
        disarm_i = 1'b1;
        step();
        disarm_i = 1'b0;
        look();
        check_val("sw_dis_status", 32'(status_o), 32'd1);

`ifdef PCAP_SEQ_LIMIT_EN
        max_samples_i = 32'd3;
        arm();
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                exp_q.push_back(6'd11);
                exp_q.push_back(6'd12);
            end
            cap();
            repeat (5) step();
        end
        look();
        check_val("lim_count",  sample_count_o, 32'd3);
        check_val("lim_done",   done_cnt - d0,  32'd1);
        check_val("lim_status", 32'(status_o),  32'd0);
        check_val("lim_actv",   32'(actv_o),    32'd0);
        max_samples_i = '0;
`endif

        // Reset in mid-sequence: valid drops, no done pulse.
        arm();
        exp_q.push_back(6'd11);
        cap();
        step();
        d0 = done_cnt;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        look();
        check_val("mrst_valid",  32'(mux_valid_o), 32'd0);
        check_val("mrst_actv",   32'(actv_o),      32'd0);
        check_val("mrst_done",   done_cnt - d0,    32'd0);
        check_val("mrst_status", 32'(status_o),    32'd0);

        step(); step(); look();
        check_val("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
